// File: rtl/vector_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : vector_mult_pipe
// Description : N-lane signed fixed-point vector multiplier. Each beat is
//               either vector x scalar (mode=0) or vector x vector (mode=1).
//               Every lane rounds half up, shifts out FRAC fraction bits and
//               saturates to BITWIDTH, raising a per-lane flag when it clamps.
//               A fixed LAT-stage multiply pipeline feeds a show-ahead output
//               FIFO. Input credit counts queued plus in-flight beats, so the
//               pipeline never stalls and downstream backpressure loses no
//               data.
// Ports       : clk, rst (async, active-high)
//               in0 / in1_vec / in1_scalar / mode / in_valid / in_last /
//               in_ready        : input beat and its handshake
//               out / out_sat / out_valid / out_last / out_ready
//                               : output beat and its handshake
//               pkt_cnt         : completed packets (out_last beats popped)
// Revision    : 1.0 - initial release
// ============================================================================
module vector_mult_pipe #(
  parameter int BITWIDTH = 16,
  parameter int N        = 8,
  parameter int FRAC     = 8,
  parameter int LAT      = 3,
  parameter int DEPTH    = 6,
  parameter int PKT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N*BITWIDTH-1:0] in0,
  input  logic [N*BITWIDTH-1:0] in1_vec,
  input  logic [BITWIDTH-1:0]   in1_scalar,
  input  logic                  mode,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [N*BITWIDTH-1:0] out,
  output logic [N-1:0]          out_sat,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [PKT_W-1:0]      pkt_cnt
);

  localparam int c_PRW = 2 * BITWIDTH;                    // full product width
  localparam int c_PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1; // FIFO pointer width
  localparam int c_CW  = $clog2(DEPTH + 1);               // FIFO count width
  localparam int c_OW  = $clog2(DEPTH + LAT + 1);         // occupancy width
  localparam int c_EW  = 1 + N + N * BITWIDTH;            // {last, sat, data}

  // Saturation bounds expressed at product width: 2^(B-1)-1 and its inverse.
  localparam logic signed [c_PRW-1:0] c_MAX =
    {{(BITWIDTH + 1){1'b0}}, {(BITWIDTH - 1){1'b1}}};
  localparam logic signed [c_PRW-1:0] c_MIN = ~c_MAX;

  // --------------------------------------------------------------------------
  // Input acceptance and credit
  // --------------------------------------------------------------------------
  logic [c_CW-1:0] cnt_q;
  logic [LAT-1:0]  vld_q;
  logic [c_OW-1:0] w_occ;
  logic            w_acc;

  // Occupancy is built from registers only, so a pop this cycle frees credit
  // only after the count register has been updated.
  always_comb begin
    w_occ = c_OW'(cnt_q);
    for (int s = 0; s < LAT; s++) begin
      w_occ = w_occ + c_OW'(vld_q[s]);
    end
  end

  assign in_ready = ~rst & (w_occ < c_OW'(DEPTH));
  assign w_acc    = in_valid & in_ready;

  // --------------------------------------------------------------------------
  // Lane multipliers (operands captured as a full product at acceptance)
  // --------------------------------------------------------------------------
  logic [N*c_PRW-1:0] w_prod;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mul
      logic signed [BITWIDTH-1:0] w_a;
      logic signed [BITWIDTH-1:0] w_b;
      logic signed [c_PRW-1:0]    w_p;
      assign w_a = in0[gi*BITWIDTH +: BITWIDTH];
      assign w_b = mode ? in1_vec[gi*BITWIDTH +: BITWIDTH] : in1_scalar;
      assign w_p = w_a * w_b;
      assign w_prod[gi*c_PRW +: c_PRW] = w_p;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Multiply pipeline: LAT stages, never stalls
  // --------------------------------------------------------------------------
  logic [N*c_PRW-1:0] prod_q [LAT];
  logic [LAT-1:0]     last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      last_q <= '0;
    end else begin
      vld_q[0]  <= w_acc;
      last_q[0] <= in_last;
      for (int s = 1; s < LAT; s++) begin
        vld_q[s]  <= vld_q[s-1];
        last_q[s] <= last_q[s-1];
      end
    end
  end

  // Product data is qualified by the valid chain, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      prod_q[0] <= w_prod;
    end
    for (int s = 1; s < LAT; s++) begin
      if (vld_q[s-1]) begin
        prod_q[s] <= prod_q[s-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Round, shift and saturate at the pipeline exit
  // --------------------------------------------------------------------------
  logic [N*BITWIDTH-1:0] w_res;
  logic [N-1:0]          w_sat;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rs
      logic signed [c_PRW-1:0] w_p;
      logic signed [c_PRW-1:0] w_s;
      logic                    w_hi;
      logic                    w_lo;

      assign w_p = prod_q[LAT-1][gi*c_PRW +: c_PRW];

      if (FRAC > 0) begin : g_rnd
        // Adding half an LSB then flooring gives round-half-up. The largest
        // product is 2^(2B-2), so the addition cannot overflow c_PRW.
        localparam logic signed [c_PRW-1:0] c_HALF = c_PRW'(1) << (FRAC - 1);
        logic signed [c_PRW-1:0] w_r;
        assign w_r = w_p + c_HALF;
        assign w_s = w_r >>> FRAC;
      end else begin : g_nornd
        assign w_s = w_p;
      end

      assign w_hi = (w_s > c_MAX);
      assign w_lo = (w_s < c_MIN);
      assign w_sat[gi] = w_hi | w_lo;
      assign w_res[gi*BITWIDTH +: BITWIDTH] =
        w_hi ? c_MAX[BITWIDTH-1:0] :
        w_lo ? c_MIN[BITWIDTH-1:0] : w_s[BITWIDTH-1:0];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Show-ahead output FIFO with registered head
  // --------------------------------------------------------------------------
  logic [c_EW-1:0]       mem_q [DEPTH];
  logic [c_PW-1:0]       wr_q;
  logic [c_PW-1:0]       rd_q;
  logic [c_PW-1:0]       rd_d;
  logic [c_CW-1:0]       cnt_d;
  logic [c_EW-1:0]       w_wdata;
  logic [c_EW-1:0]       w_head;
  logic                  w_push;
  logic                  w_pop;
  logic                  out_vld_q;
  logic                  out_last_q;
  logic [N-1:0]          out_sat_q;
  logic [N*BITWIDTH-1:0] out_q;
  logic [PKT_W-1:0]      pkt_q;

  function automatic logic [c_PW-1:0] f_inc(input logic [c_PW-1:0] p);
    return (p == c_PW'(DEPTH - 1)) ? '0 : p + c_PW'(1);
  endfunction

  // Credit guarantees space, so the pipeline exit writes unconditionally.
  assign w_push  = vld_q[LAT-1];
  assign w_wdata = {last_q[LAT-1], w_sat, w_res};
  assign w_pop   = out_vld_q & out_ready;

  // The head register is loaded with whatever will sit at the read pointer
  // after this edge. If the FIFO drains to empty in the same cycle that a
  // beat is written, that new beat bypasses the memory straight to the head.
  always_comb begin
    rd_d   = w_pop ? f_inc(rd_q) : rd_q;
    cnt_d  = cnt_q + c_CW'(w_push) - c_CW'(w_pop);
    w_head = mem_q[rd_d];
    if ((cnt_q - c_CW'(w_pop)) == '0) begin
      w_head = w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_q] <= w_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_sat_q  <= '0;
      out_q      <= '0;
      pkt_q      <= '0;
    end else begin
      if (w_push) begin
        wr_q <= f_inc(wr_q);
      end
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      out_vld_q <= (cnt_d != '0);
      // Output fields hold their last value while the FIFO is empty.
      if (cnt_d != '0) begin
        {out_last_q, out_sat_q, out_q} <= w_head;
      end
      if (w_pop & out_last_q) begin
        pkt_q <= pkt_q + PKT_W'(1);
      end
    end
  end

  assign out_valid = out_vld_q;
  assign out_last  = out_last_q;
  assign out_sat   = out_sat_q;
  assign out       = out_q;
  assign pkt_cnt   = pkt_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_mult_pipe
// Description : Directed self-checking bench for vector_mult_pipe with the
//               default parameters (Q8.8, 8 lanes, LAT=3, DEPTH=6).
//               Expected values are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_mult_pipe;

  localparam int BW    = 16;
  localparam int N     = 8;
  localparam int LAT   = 3;
  localparam int DEPTH = 6;
  localparam int PKT_W = 8;

  logic              clk;
  logic              rst;
  logic [N*BW-1:0]   in0;
  logic [N*BW-1:0]   in1_vec;
  logic [BW-1:0]     in1_scalar;
  logic              mode;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [N*BW-1:0]   out;
  logic [N-1:0]      out_sat;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;
  logic [PKT_W-1:0]  pkt_cnt;

  vector_mult_pipe #(
    .BITWIDTH (BW),
    .N        (N),
    .FRAC     (8),
    .LAT      (LAT),
    .DEPTH    (DEPTH),
    .PKT_W    (PKT_W)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in0        (in0),
    .in1_vec    (in1_vec),
    .in1_scalar (in1_scalar),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out        (out),
    .out_sat    (out_sat),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .pkt_cnt    (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int idx;
  int rx;
  int nerr;
  int nlow;
  int nvld;
  logic rdy;
  logic [N*BW-1:0] exp_v;

  task automatic check(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [N*BW-1:0] rep(input logic [BW-1:0] v);
    logic [N*BW-1:0] r;
    for (int i = 0; i < N; i++) r[i*BW +: BW] = v;
    return r;
  endfunction

  // Advance one clock; everything afterwards happens 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of the backpressure sequence: offer beat idx (value idx+1,
  // last on beat 9), record a pop, advance, and note acceptance.
  task automatic bp_cycle();
    if (idx < 10) begin
      in_valid = 1'b1;
      in0      = rep(16'(idx + 1));
      in_last  = (idx == 9);
    end else begin
      in_valid = 1'b0;
    end
    rdy = in_ready;
    if (out_valid && out_ready) begin
      check($sformatf("bp_beat%0d", rx), {out_last, out},
            {(rx == 9), rep(16'(rx + 1))});
      rx++;
    end
    tick();
    if (rdy && idx < 10) idx++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset state ----------------
    rst = 1'b1; in0 = '0; in1_vec = '0; in1_scalar = '0; mode = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    tick(); tick(); tick();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_outputs", {out_valid, out_last, out_sat, out}, '0);
    check("rst_pkt_cnt", pkt_cnt, '0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", in_ready, 1'b1);

    // ---------------- basic vector x scalar ----------------
    out_ready = 1'b1;
    in0 = rep(16'h0180); in1_scalar = 16'h0200; mode = 1'b0;
    in_valid = 1'b1; in_last = 1'b0;
    tick();                       // accept edge
    in_valid = 1'b0;
    tick(); check("vs_lat1", out_valid, 1'b0);
    tick(); check("vs_lat2", out_valid, 1'b0);
    tick();
    check("vs_valid", out_valid, 1'b1);
    check("vs_data", {out_last, out_sat, out}, {1'b0, 8'h00, rep(16'h0300)});
    tick();
    check("vs_empty_hold", {out_valid, out}, {1'b0, rep(16'h0300)});

    // ---------------- vector x vector, rounding; then saturation ---------
    in0 = '0; in1_vec = '0;
    in0[0*BW +: BW] = 16'h0001; in1_vec[0*BW +: BW] = 16'h0080; // half -> up
    in0[1*BW +: BW] = 16'hFF00; in1_vec[1*BW +: BW] = 16'h0100; // -1 x 1
    in0[2*BW +: BW] = 16'h0001; in1_vec[2*BW +: BW] = 16'h007F; // < half
    in0[3*BW +: BW] = 16'hFFFF; in1_vec[3*BW +: BW] = 16'h0080; // -half -> 0
    in0[4*BW +: BW] = 16'h0300; in1_vec[4*BW +: BW] = 16'hFE00; // 3 x -2
    in1_scalar = 16'h7FFF; mode = 1'b1; in_valid = 1'b1; in_last = 1'b1;
    tick();
    in0 = '0; in1_vec = '0;
    in0[0*BW +: BW] = 16'h7FFF; in1_vec[0*BW +: BW] = 16'h7FFF;
    in0[1*BW +: BW] = 16'h8000; in1_vec[1*BW +: BW] = 16'h7FFF;
    in0[2*BW +: BW] = 16'h8000; in1_vec[2*BW +: BW] = 16'h8000;
    in0[3*BW +: BW] = 16'h4000; in1_vec[3*BW +: BW] = 16'h0100;
    in0[4*BW +: BW] = 16'h7FFF; in1_vec[4*BW +: BW] = 16'h0100;
    in0[5*BW +: BW] = 16'h8000; in1_vec[5*BW +: BW] = 16'h0100;
    in0[6*BW +: BW] = 16'h8000; in1_vec[6*BW +: BW] = 16'hFF00;
    in_last = 1'b0;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    exp_v = '0;
    exp_v[0*BW +: BW] = 16'h0001;
    exp_v[1*BW +: BW] = 16'hFF00;
    exp_v[4*BW +: BW] = 16'hFA00;
    check("vv_data", {out_valid, out_last, out_sat, out},
          {1'b1, 1'b1, 8'h00, exp_v});
    tick();
    exp_v = '0;
    exp_v[0*BW +: BW] = 16'h7FFF;
    exp_v[1*BW +: BW] = 16'h8000;
    exp_v[2*BW +: BW] = 16'h7FFF;
    exp_v[3*BW +: BW] = 16'h4000;
    exp_v[4*BW +: BW] = 16'h7FFF;
    exp_v[5*BW +: BW] = 16'h8000;
    exp_v[6*BW +: BW] = 16'h7FFF;
    check("sat_data", {out_valid, out_last, out_sat, out},
          {1'b1, 1'b0, 8'b0100_0111, exp_v});
    tick();
    check("pkt_after_vv", pkt_cnt, 8'd1);

    // ---------------- backpressure ----------------
    mode = 1'b0; in1_scalar = 16'h0100; out_ready = 1'b0;
    idx = 0; rx = 0;
    for (int c = 0; c < 12; c++) bp_cycle();
    check("bp_accepted", idx, DEPTH);
    check("bp_ready_low", in_ready, 1'b0);
    check("bp_stall_head", {out_valid, out_last, out}, {1'b1, 1'b0, rep(16'h0001)});
    tick(); tick();
    check("bp_stall_stable", {out_valid, out_last, out}, {1'b1, 1'b0, rep(16'h0001)});
    out_ready = 1'b1;
    for (int c = 0; c < 60 && rx < 10; c++) bp_cycle();
    in_valid = 1'b0;
    check("bp_rx_count", rx, 10);
    tick(); tick();
    check("bp_drained", out_valid, 1'b0);
    check("bp_pkt_cnt", pkt_cnt, 8'd2);

    // ---------------- reset mid-stream: 2 queued, 3 in flight ----------
    out_ready = 1'b0; in_last = 1'b0; in0 = rep(16'h0700);
    in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    in_valid = 1'b1;
    tick(); tick(); tick();
    in_valid = 1'b0;
    check("mid_pre_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_out", {out_valid, out}, '0);
    check("mid_rst_pkt", pkt_cnt, '0);
    check("mid_rst_ready", in_ready, 1'b0);
    tick(); tick();
    rst = 1'b0; out_ready = 1'b1;
    nvld = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out_valid) nvld++;
    end
    check("mid_no_stale", nvld, 0);
    in0 = rep(16'h0280); in1_scalar = 16'hFF00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("mid_new_early", out_valid, 1'b0);
    tick();
    check("mid_new_data", {out_valid, out_last, out_sat, out},
          {1'b1, 1'b0, 8'h00, rep(16'hFD80)});

    // ---------------- throughput and packet counter ----------------
    in1_scalar = 16'h0100; in_last = 1'b1; out_ready = 1'b1;
    tick();
    idx = 0; rx = 0; nerr = 0; nlow = 0;
    for (int c = 0; c < 300 + LAT + 2; c++) begin
      if (idx < 300) begin
        in_valid = 1'b1;
        in0 = rep(16'(idx));
        if (!in_ready) nlow++;
      end else begin
        in_valid = 1'b0;
      end
      rdy = in_ready;
      if (out_valid) begin
        if ({out_last, out} !== {1'b1, rep(16'(rx))}) nerr++;
        rx++;
      end
      tick();
      if (rdy && in_valid) idx++;
    end
    in_valid = 1'b0;
    check("thr_ready_low_cycles", nlow, 0);
    check("thr_rx_count", rx, 300);
    check("thr_data_errs", nerr, 0);
    check("thr_pkt_cnt", pkt_cnt, 8'd44);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
